// File: rtl/pipe_pkg.sv
// Shared defaults and control-bit layout for the writeback pipeline stage.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CTRL_W_DEF = 2;
  localparam int unsigned RD_W_DEF   = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  // Bit positions inside the control field.
  localparam int unsigned CTRL_MEM_TO_REG = 0;
  localparam int unsigned CTRL_REG_WRITE  = 1;

  // Decode the regWrite bit from a control field.
  function automatic logic reg_write(input logic [CTRL_W_DEF-1:0] ctrl);
    return ctrl[CTRL_REG_WRITE];
  endfunction

  // Decode the memToReg bit from a control field.
  function automatic logic mem_to_reg(input logic [CTRL_W_DEF-1:0] ctrl);
    return ctrl[CTRL_MEM_TO_REG];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc cycles and holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline register with registered in_ready,
// flush, zeroed bubbles and a saturating back-pressure counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned RD_W   = RD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [RD_W-1:0]   main_rd_q, main_rd_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;

  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_ready_q, in_ready_d;
  logic in_fire, out_fire, stall;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid_q & out_ready;
  assign stall    = main_valid_q & ~out_ready;

  // Entry movement: main refills from skid first so order is preserved.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_rd_d    = main_rd_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;

    if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_rd_d    = skid_rd_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_rd_d    = in_rd;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // in_ready_q guarantees skid is empty here.
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_rd_d    = in_rd;
      skid_data_d  = in_data;
    end

    // Flush drops whatever is held or was just accepted; an output transfer
    // this cycle has already completed on the interface.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end

    // Registered ready mirrors next-cycle skid occupancy, so out_ready
    // never reaches in_ready combinationally.
    in_ready_d = ~skid_valid_d;
  end

  // Entry storage and ready flop; reset wins over flush and transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_rd_q    <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_rd_q    <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_rd_q    <= main_rd_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Bubbles present all-zero fields so regWrite can never leak out.
  always_comb begin
    out_valid = main_valid_q;
    out_ctrl  = '0;
    out_rd    = '0;
    out_data  = '0;
    if (main_valid_q) begin
      out_ctrl = main_ctrl_q;
      out_rd   = main_rd_q;
      out_data = main_data_q;
    end
  end

  assign in_ready = in_ready_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall),
    .count(stall_cnt)
  );

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the payload width (read data and ALU result packed together).
REQ-002 The block SHALL have parameter CTRL_W, default 2, giving the control-bit width (bit0 memToReg, bit1 regWrite).
REQ-003 The block SHALL have parameter RD_W, default 5, giving the destination-register index width.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 flush  in  1  invalidates all held entries.
REQ-008 in_valid  in  1  upstream entry present.
REQ-009 in_ready  out  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  in  CTRL_W,  in_rd  in  RD_W,  in_data  in  DATA_W  upstream entry fields.
REQ-011 out_valid  out  1,  out_ready  in  1  downstream handshake.
REQ-012 out_ctrl  out  CTRL_W,  out_rd  out  RD_W,  out_data  out  DATA_W  head-entry fields.
REQ-013 stall_cnt  out  CNT_W  saturating count of back-pressure cycles.

Function
REQ-014 The stage SHALL hold two entries, main (head) and skid, each with a valid bit.
REQ-015 A transfer SHALL occur on input when in_valid and in_ready are both 1, and on output when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL be a registered signal equal to NOT skid_valid, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal main_valid.
REQ-018 The out_ctrl, out_rd and out_data outputs SHALL be forced to 0 whenever out_valid is 0, so a bubble never asserts regWrite.
REQ-019 Latency SHALL be 1 cycle from input transfer to out_valid when the stage is empty, and sustained throughput SHALL be 1 entry per cycle while out_ready is held at 1.
REQ-020 When main is empty or an output transfer occurs, main SHALL load the skid entry if skid is valid, otherwise the input entry (if one transfers), otherwise go invalid.
REQ-021 When main is valid, no output transfer occurs, and an input transfer occurs, skid SHALL capture the input entry.
REQ-022 Skid SHALL clear when its entry moves to main.
REQ-023 Entries SHALL never be reordered, duplicated or dropped except by flush or rst.
REQ-024 When flush is 1, both valid bits SHALL clear on the next edge, and in_ready SHALL be 1 in the next cycle.
REQ-025 Any input transfer coincident with flush SHALL be accepted and discarded.
REQ-026 Any output transfer coincident with flush SHALL complete normally.
REQ-027 stall_cnt SHALL increment by 1 on each cycle in which out_valid is 1 and out_ready is 0, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by flush.

Reset
REQ-028 While rst is 1 at an edge, main_valid, skid_valid and stall_cnt SHALL become 0, and in_ready SHALL become 1.
REQ-029 After reset, all outputs SHALL read 0 except in_ready, which SHALL read 1.
REQ-030 rst SHALL take priority over flush and over all transfers.
REQ-031 An rst asserted mid-stall SHALL discard held entries without producing an output transfer.

Structure
REQ-032 Package pipe_pkg SHALL hold RD_W default, the CTRL_MEM_TO_REG=0 and CTRL_REG_WRITE=1 bit indices, and the default DATA_W.
REQ-033 The saturating counter SHALL be a sub-module named sat_counter, parametrised by CNT_W, with ports clk, rst, inc and count.
REQ-034 Entry storage SHALL remain in the top level.

Verification
REQ-035 Reset, then idle: SHALL see in_ready=1, out_valid=0, out_ctrl=0, stall_cnt=0.
REQ-036 Stream 4 entries (data 0x1..0x4, rd 1..4, ctrl 2'b11) with out_ready=1: SHALL see each entry on out_* exactly 1 cycle after acceptance, back-to-back.
REQ-037 Hold out_ready=0 and offer A then B: SHALL see A on out_*, B in skid, in_ready=0, and stall_cnt counting up. Then raise out_ready: SHALL see A then B in order, and in_ready return to 1.
REQ-038 Flush with main and skid full, plus a simultaneous input C: next cycle SHALL see out_valid=0, in_ready=1, and C never appearing on out_*.
REQ-039 With CNT_W=3 and out_ready=0 for 10 cycles while valid: SHALL see stall_cnt stick at 7, and flush SHALL leave it at 7.
REQ-040 Assert rst while the stage is stalled with 2 entries: next cycle SHALL see out_valid=0, stall_cnt=0, and no output transfer recorded.
